fir_mac: RTL and testbench

- Multiply-accumulate stage of the FIR datapath, directly downstream of the 5-entry sample delay-line memory.
- Takes a snapshot of the packed 5-sample window plus the newest-sample slot index, then computes y = sum over k of c[k]*x[n-k], serially, one tap per cycle.
- Presents a full-precision result and an 8-bit saturated result on a valid/ready output.
- Coefficients are programmable through a staging bank. The bank is committed at the start of each computation.

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_sat.sv | 27 ++
 rtl/fir_mac.sv | 137 +++++++++++++
 tb/tb_fir_mac.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared parameters, FSM state type and slot-index helper for the FIR MAC stage.
package fir_pkg;

  localparam int N_TAPS_DEF = 5;
  localparam int DW_DEF     = 8;
  localparam int CW_DEF     = 8;
  localparam int ACC_W_DEF  = 19;
  localparam int SHIFT_DEF  = 7;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slot holding x[n-k]: head is first folded into 0..n-1, then (h - k) wraps by +n.
  // Mod-2^IDX_W arithmetic is exact here because every final result is below n.
  function automatic logic [IDX_W-1:0] slot_idx(input logic [IDX_W-1:0] head,
                                                input logic [IDX_W-1:0] k,
                                                input logic [IDX_W-1:0] n);
    logic [IDX_W-1:0] h;
    h = (head >= n) ? head - n : head;
    return (h >= k) ? h - k : h + n - k;
  endfunction

endpackage

// File: rtl/fir_sat.sv
// Combinational arithmetic right shift followed by clamp to the signed DW range.
module fir_sat #(
  parameter int ACC_W = 19,
  parameter int DW    = 8,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [DW-1:0]    o_sat
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

  logic signed [ACC_W-1:0] w_sh;

  assign w_sh = i_acc >>> SHIFT;

  always_comb begin
    o_sat = w_sh[DW-1:0];
    if (w_sh > SAT_MAX) begin
      o_sat = SAT_MAX[DW-1:0];
    end else if (w_sh < SAT_MIN) begin
      o_sat = SAT_MIN[DW-1:0];
    end
  end

endmodule

// File: rtl/fir_mac.sv
// Serial one-tap-per-cycle multiply-accumulate over a snapshotted sample window,
// with a staging coefficient bank committed at each window acceptance.
module fir_mac
  import fir_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int DW     = DW_DEF,
  parameter int CW     = CW_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_TAPS*DW-1:0]    i_taps_in,
  input  logic [IDX_W-1:0]        i_head,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic                    i_coef_we,
  input  logic [IDX_W-1:0]        i_coef_addr,
  input  logic [CW-1:0]           i_coef_wdata,
  output logic signed [ACC_W-1:0] o_y,
  output logic signed [DW-1:0]    o_y_sat,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_busy
);

  localparam logic [IDX_W-1:0] N_IDX  = IDX_W'(N_TAPS);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_TAPS - 1);

  state_t                  r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;
  logic signed [ACC_W-1:0] r_y;
  logic signed [DW-1:0]    r_y_sat;
  logic signed [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0]        r_k;
  logic [IDX_W-1:0]        r_head;
  logic signed [DW-1:0]    r_taps     [N_TAPS];
  logic signed [CW-1:0]    r_coef_stg [N_TAPS];
  logic signed [CW-1:0]    r_coef_act [N_TAPS];

  logic [IDX_W-1:0]        w_slot;
  logic signed [DW-1:0]    w_x;
  logic signed [CW-1:0]    w_c;
  logic signed [DW+CW-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [DW-1:0]    w_sat;

  assign w_slot     = slot_idx(r_head, r_k, N_IDX);
  assign w_x        = r_taps[w_slot];
  assign w_c        = r_coef_act[r_k];
  assign w_prod     = w_x * w_c;
  assign w_prod_ext = {{(ACC_W-DW-CW){w_prod[DW+CW-1]}}, w_prod};
  assign w_acc_nxt  = r_acc + w_prod_ext;

  fir_sat #(
    .ACC_W (ACC_W),
    .DW    (DW),
    .SHIFT (SHIFT)
  ) u_sat (
    .i_acc (w_acc_nxt),
    .o_sat (w_sat)
  );

  // Staging bank is written freely; the active bank only changes on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) r_coef_stg[i] <= '0;
    end else if (i_coef_we && (i_coef_addr < N_IDX)) begin
      r_coef_stg[i_coef_addr] <= i_coef_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_y         <= '0;
      r_y_sat     <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_head      <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        r_taps[i]     <= '0;
        r_coef_act[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            for (int i = 0; i < N_TAPS; i++) r_taps[i] <= i_taps_in[i*DW +: DW];
            r_head     <= i_head;
            r_coef_act <= r_coef_stg;
            r_acc      <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_y         <= w_acc_nxt;
            r_y_sat     <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_y         = r_y;
  assign o_y_sat     = r_y_sat;

endmodule

// File: tb/tb_fir_mac.sv
// Self-checking bench for fir_mac: directed table, corner sequences and random vs a reference model.
module tb_fir_mac;

  logic               clk;
  logic               rst_n;
  logic [39:0]        taps_in;
  logic [2:0]         head;
  logic               in_valid;
  logic               in_ready;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic [7:0]         coef_wdata;
  logic signed [18:0] y;
  logic signed [7:0]  y_sat;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int m_coef [5];

  typedef struct packed {
    logic [39:0] taps;
    logic [39:0] coefs;
    logic [2:0]  hd;
    int          exp_y;
    int          exp_sat;
  } vec_t;

  vec_t tbl [8];

  fir_mac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_taps_in    (taps_in),
    .i_head       (head),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_coef_we    (coef_we),
    .i_coef_addr  (coef_addr),
    .i_coef_wdata (coef_wdata),
    .o_y          (y),
    .o_y_sat      (y_sat),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [39:0] pack5(input int a, input int b, input int c, input int d, input int e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Reference: y = sum_k c[k] * x[(head mod 5) - k, wrapped], then floor-shift and clamp.
  function automatic longint model_y(input logic [39:0] t, input int h);
    longint sum = 0;
    int hh = h % 5;
    for (int k = 0; k < 5; k++) begin
      int idx = (hh - k + 5) % 5;
      int x = int'($signed(t[idx*8 +: 8]));
      sum += longint'(x) * longint'(m_coef[k]);
    end
    return sum;
  endfunction

  function automatic longint model_sat(input longint v);
    longint s = v >>> 7;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1;
    coef_addr = 3'(addr);
    coef_wdata = 8'(val);
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    if (addr < 5) m_coef[addr] = int'($signed(8'(val)));
  endtask

  task automatic write_all(input logic [39:0] c);
    for (int k = 0; k < 5; k++) write_coef(k, int'(c[k*8 +: 8]));
  endtask

  task automatic run_window(input logic [39:0] t, input int h,
                            output longint ry, output longint rs, output int lat);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", longint'(in_ready), 1);
    taps_in = t;
    head = 3'(h);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_in_mac", longint'(busy), 1);
    check("in_ready_low_in_mac", longint'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ry = longint'(y);
    rs = longint'(y_sat);
    @(negedge clk);
    check("out_valid_drop", longint'(out_valid), 0);
    check("in_ready_back", longint'(in_ready), 1);
  endtask

  initial begin
    longint ry, rs;
    int lat, n;
    logic [39:0] basic;
    logic [39:0] t;
    logic [39:0] c;
    int h;
    int seen;

    basic = pack5(10, 20, 30, 40, 50);
    tbl[0] = '{taps: basic, coefs: pack5(1, 2, 3, 4, 5), hd: 3'd2, exp_y: 500, exp_sat: 3};
    tbl[1] = '{taps: pack5(-128, -128, -128, -128, -128), coefs: pack5(-128, -128, -128, -128, -128),
               hd: 3'd0, exp_y: 81920, exp_sat: 127};
    tbl[2] = '{taps: pack5(-128, -128, -128, -128, -128), coefs: pack5(127, 127, 127, 127, 127),
               hd: 3'd3, exp_y: -81280, exp_sat: -128};
    tbl[3] = '{taps: basic, coefs: pack5(1, 2, 3, 4, 5), hd: 3'd7, exp_y: 500, exp_sat: 3};
    tbl[4] = '{taps: basic, coefs: pack5(1, 2, 3, 4, 5), hd: 3'd0, exp_y: 450, exp_sat: 3};
    tbl[5] = '{taps: basic, coefs: pack5(1, 2, 3, 4, 5), hd: 3'd4, exp_y: 350, exp_sat: 2};
    tbl[6] = '{taps: basic, coefs: pack5(1, 2, 3, 4, 5), hd: 3'd5, exp_y: 450, exp_sat: 3};
    tbl[7] = '{taps: pack5(-1, 0, 0, 0, 0), coefs: pack5(1, 0, 0, 0, 0), hd: 3'd0, exp_y: -1, exp_sat: -1};

    for (int k = 0; k < 5; k++) m_coef[k] = 0;
    rst_n = 1'b0;
    taps_in = '0;
    head = '0;
    in_valid = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    out_ready = 1'b1;
    #23;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_y", longint'(y), 0);
    check("rst_y_sat", longint'(y_sat), 0);
    check("rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      write_all(tbl[i].coefs);
      run_window(tbl[i].taps, int'(tbl[i].hd), ry, rs, lat);
      check($sformatf("tbl%0d_y", i), ry, longint'(tbl[i].exp_y));
      check($sformatf("tbl%0d_sat", i), rs, longint'(tbl[i].exp_sat));
      check($sformatf("tbl%0d_lat", i), longint'(lat), 5);
    end

    // Write coinciding with acceptance lands in staging only
    write_all(pack5(1, 2, 3, 4, 5));
    taps_in = basic;
    head = 3'd2;
    in_valid = 1'b1;
    coef_we = 1'b1;
    coef_addr = 3'd1;
    coef_wdata = 8'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b0;
    m_coef[1] = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("same_cycle_write_cur", longint'(y), 500);
    @(negedge clk);
    run_window(basic, 2, ry, rs, lat);
    check("same_cycle_write_next", ry, 460);

    // Out-of-range coefficient addresses are dropped
    write_all(pack5(1, 2, 3, 4, 5));
    write_coef(5, 99);
    write_coef(6, 99);
    write_coef(7, 99);
    run_window(basic, 2, ry, rs, lat);
    check("bad_addr_ignored", ry, 500);

    // Backpressure with c0 rewritten mid-computation
    out_ready = 1'b0;
    taps_in = basic;
    head = 3'd2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write_coef(0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_first_y", longint'(y), 500);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_y", longint'(y), 500);
      check("bp_in_ready_low", longint'(in_ready), 0);
      check("bp_out_valid", longint'(out_valid), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_release_drop", longint'(out_valid), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("bp_next_y", longint'(y), 470);
    check("bp_next_model", longint'(y), model_y(basic, 2));
    check("bp_next_sat", longint'(y_sat), 3);
    @(negedge clk);

    // Reset on MAC cycle 3
    write_all(pack5(1, 2, 3, 4, 5));
    taps_in = basic;
    head = 3'd2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_y", longint'(y), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_busy", longint'(busy), 0);
    for (int k = 0; k < 5; k++) m_coef[k] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_out_valid", longint'(seen), 0);
    check("midrst_in_ready_after", longint'(in_ready), 1);
    run_window(basic, 2, ry, rs, lat);
    check("midrst_banks_zero_y", ry, 0);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      c = {$urandom, $urandom};
      t = {$urandom, $urandom};
      if (i % 8 == 0) t = pack5(-128, -128, -128, -128, -128);
      if (i % 8 == 1) c = pack5(127, -128, 127, -128, 127);
      h = int'($urandom_range(0, 7));
      write_all(c);
      if ($urandom_range(0, 3) == 0) write_coef(int'($urandom_range(5, 7)), int'($urandom_range(0, 255)));
      run_window(t, h, ry, rs, lat);
      check($sformatf("rnd%0d_y", i), ry, model_y(t, h));
      check($sformatf("rnd%0d_sat", i), rs, model_sat(model_y(t, h)));
      check($sformatf("rnd%0d_lat", i), longint'(lat), 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
